sdram_cmd_sched: RTL and testbench
==================================

Name: sdram_cmd_sched

Overview:
- Sequences the on-board SDRAM for GR8RAM: power-up init, Apple bus read/write accesses, and periodic auto-refresh.
- Replaces the fixed PS-slot command table with a request-driven FSM, so refresh continues even when PHI0 is stopped.
- Drives the SDRAM command pins, the data-bus output enable, an address-mux select and a read-data capture strobe.
- The address mux, data registers and Apple decode stay outside this block.

Parameters:
- INIT_WAIT, 5000, C25M cycles of NOP after reset before init (200 us at 25 MHz).
- REF_INTERVAL, 390, C25M cycles per refresh credit (15.6 us).
- REF_DEBT_MAX, 7, saturation value of the refresh debt counter; RefDebt is 3 bits.

Ports:
- C25M  in  1  system clock, all state on its rising edge.
- nRESr  in  1  reset, asynchronous, active-low.
- CycStart  in  1  one-cycle pulse at a synchronized PHI0 rising edge.
- ReqRD  in  1  read request, sampled only when CycStart=1.
- ReqWR  in  1  write request, sampled only when CycStart=1; write data is valid from that edge.
- nRCS, nRAS, nCAS, nSWE  out  1 each  registered SDRAM command.
- SDOE  out  1  SD bus output enable.
- AMux  out  2  address select: 0 = idle, 1 = row, 2 = column, 3 = mode word.
- RDLatch  out  1  one-cycle strobe: SD holds read data.
- Ready  out  1  init complete.
- Busy  out  1  FSM not in IDLE.
- RefDebt  out  3  outstanding refreshes.
- Overrun  out  1  sticky: a request was lost.

Behaviour:
- Reset values:
  - command pins all 1 (NOP-deselect); SDOE=0, AMux=0, RDLatch=0.
  - Ready=0, Busy=1, RefDebt=0, Overrun=0.
  - FSM enters INIT_WAIT.
- Registering: all outputs are registered. A command "at k+n" means the outputs hold it for exactly the cycle after edge k+n. Every non-command cycle is NOP with nRCS=1.
- Init sequence: INIT_WAIT (INIT_WAIT cycles) → PC-all → NOP → AREF → 3×NOP → AREF → 3×NOP → LDM (AMux=3) → 2×NOP → IDLE. Ready rises on IDLE entry and stays 1 until reset.
- Command encodings (nRCS,nRAS,nCAS,nSWE):
  - ACT = 0,0,1,1
  - RD = 0,1,0,1
  - WR-AP = 0,1,0,0
  - PC-all = 0,0,1,0
  - AREF = 0,0,0,1
  - LDM = 0,0,0,0
- Request capture:
  - When Ready=1 and CycStart=1, ReqWR or ReqRD sets a one-entry pending slot, with type write if ReqWR=1 (ReqWR wins if both are set).
  - CycStart while pending is already set: the new request is dropped and Overrun is set.
  - CycStart with Ready=0: ignored, Overrun unaffected.
- IDLE priority, evaluated each cycle with pending as visible after that edge's capture:
  1. RefDebt==REF_DEBT_MAX → REFRESH.
  2. pending → ACCESS.
  3. RefDebt!=0 → REFRESH.
  4. otherwise stay in IDLE.
- ACCESS read, entered at edge k:
  - ACT (AMux=1) at k+1, NOP at k+2, RD (AMux=2) at k+3, NOPs at k+4 and k+5.
  - RDLatch=1 at k+5 only (CL2).
  - Back in IDLE after k+5.
- ACCESS write, entered at edge k:
  - ACT at k+1, NOP at k+2, WR-AP (AMux=2, SDOE=1) at k+3, NOPs at k+4 and k+5 (tWR+tRP).
  - SDOE=1 only at k+3.
- Pending clears on the edge ACCESS is entered, so a new CycStart can be accepted during the access.
- REFRESH: PC-all → NOP → AREF → 3×NOP, then IDLE. RefDebt decrements on the AREF cycle.
- Refresh timer:
  - Free-running from reset, period REF_INTERVAL, runs during init as well.
  - At each wrap RefDebt increments, saturating at REF_DEBT_MAX.
  - Increment and decrement on the same edge leave RefDebt unchanged.
  - Saturation does not set Overrun.
- An access or refresh in progress is never aborted.
- Reset asserted mid-operation returns all state and outputs to reset values immediately, and init restarts from INIT_WAIT.

Test Plan:
- Reset release with INIT_WAIT=20 → first PC-all output after edge 21; exact init sequence follows; Ready=1 after final NOP; RefDebt=0 if REF_INTERVAL>init length.
- Ready=1, IDLE, RefDebt=0, CycStart+ReqRD at edge k → ACT k+1 (AMux=1), RD k+3 (AMux=2), RDLatch only at k+5, Busy=0 after k+5.
- CycStart+ReqRD+ReqWR together → write sequence: WR-AP at k+3 with SDOE=1 for one cycle, no RD, no RDLatch.
- Hold CycStart low for 8×REF_INTERVAL → RefDebt climbs, and refreshes issue while idle; with refresh blocked by back-to-back accesses, RefDebt saturates at 7, then the next IDLE decision is REFRESH even with a request pending.
- Second CycStart+ReqRD one cycle after the first, while still pending → Overrun=1 (sticky); exactly one ACT issued.
- Assert nRESr at the RD cycle of an access → all command pins 1 and Ready=0 immediately; on release the full init sequence replays.

Source files
------------

// File: rtl/sdram_cmd_sched.sv
// sdram_cmd_sched: request-driven SDRAM command sequencer for GR8RAM.
// Handles power-up init, one Apple-bus read/write per request and periodic
// auto-refresh. Refresh runs from its own timer, independent of PHI0.
//
// Ports:
//   C25M, nRESr            clock, async active-low reset
//   CycStart               one-cycle pulse at a synchronized PHI0 rise
//   ReqRD, ReqWR           access request, sampled with CycStart
//   nRCS,nRAS,nCAS,nSWE    registered SDRAM command
//   SDOE                   SD data bus output enable (write data phase)
//   AMux                   address select: 0 idle, 1 row, 2 column, 3 mode
//   RDLatch                one-cycle strobe while SD holds read data
//   Ready                  init complete
//   Busy                   sequencer not idle
//   RefDebt                refreshes owed
//   Overrun                sticky: a request was dropped
module sdram_cmd_sched #(
    parameter int unsigned INIT_WAIT    = 5000,
    parameter int unsigned REF_INTERVAL = 390,
    parameter int unsigned REF_DEBT_MAX = 7
) (
    input  logic       C25M,
    input  logic       nRESr,
    input  logic       CycStart,
    input  logic       ReqRD,
    input  logic       ReqWR,
    output logic       nRCS,
    output logic       nRAS,
    output logic       nCAS,
    output logic       nSWE,
    output logic       SDOE,
    output logic [1:0] AMux,
    output logic       RDLatch,
    output logic       Ready,
    output logic       Busy,
    output logic [2:0] RefDebt,
    output logic       Overrun
);

    localparam int unsigned CNT_W = $clog2(INIT_WAIT + 16);
    localparam int unsigned TMR_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'((INIT_WAIT > 0) ? INIT_WAIT - 1 : 0);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'((REF_INTERVAL > 0) ? REF_INTERVAL - 1 : 0);
    localparam logic [2:0]       DEBT_MAX  = 3'(REF_DEBT_MAX);

    // {nRCS,nRAS,nCAS,nSWE}
    localparam logic [3:0] CMD_NOP  = 4'b1111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WRA  = 4'b0100;
    localparam logic [3:0] CMD_PCA  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LDM  = 4'b0000;

    typedef enum logic [2:0] {
        S_INIT_WAIT,
        S_INIT_SEQ,
        S_IDLE,
        S_ACCESS,
        S_REFRESH
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       step;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             pend, pend_nxt;
    logic             pend_wr, pend_wr_nxt;
    logic             acc_wr, acc_wr_nxt;
    logic             tick, dec, req;
    logic [3:0]       cmd_nxt;
    logic [1:0]       amux_nxt;
    logic             sdoe_nxt, lat_nxt, ovr_nxt, ready_nxt, busy_nxt;
    logic [2:0]       debt_nxt;

    assign step = cnt[3:0];

    // State, sequencing counter, refresh timer and all registered outputs
    always_ff @(posedge C25M or negedge nRESr) begin
        if (!nRESr) begin
            state                  <= S_INIT_WAIT;
            cnt                    <= '0;
            tmr                    <= '0;
            pend                   <= 1'b0;
            pend_wr                <= 1'b0;
            acc_wr                 <= 1'b0;
            {nRCS, nRAS, nCAS, nSWE} <= CMD_NOP;
            SDOE                   <= 1'b0;
            AMux                   <= 2'd0;
            RDLatch                <= 1'b0;
            Ready                  <= 1'b0;
            Busy                   <= 1'b1;
            RefDebt                <= 3'd0;
            Overrun                <= 1'b0;
        end else begin
            state                  <= state_nxt;
            cnt                    <= cnt_nxt;
            tmr                    <= tmr_nxt;
            pend                   <= pend_nxt;
            pend_wr                <= pend_wr_nxt;
            acc_wr                 <= acc_wr_nxt;
            {nRCS, nRAS, nCAS, nSWE} <= cmd_nxt;
            SDOE                   <= sdoe_nxt;
            AMux                   <= amux_nxt;
            RDLatch                <= lat_nxt;
            Ready                  <= ready_nxt;
            Busy                   <= busy_nxt;
            RefDebt                <= debt_nxt;
            Overrun                <= ovr_nxt;
        end
    end

    // Next state, request capture, refresh accounting and next outputs
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_nxt    = pend;
        pend_wr_nxt = pend_wr;
        acc_wr_nxt  = acc_wr;
        ovr_nxt     = Overrun;
        cmd_nxt     = CMD_NOP;
        amux_nxt    = 2'd0;
        sdoe_nxt    = 1'b0;
        lat_nxt     = 1'b0;
        dec         = 1'b0;

        tick    = (tmr == TMR_LAST);
        tmr_nxt = tick ? '0 : tmr + TMR_W'(1);

        // One-entry request slot; a second request while full is lost
        req = CycStart && Ready && (ReqRD || ReqWR);
        if (req) begin
            if (pend) begin
                ovr_nxt = 1'b1;
            end else begin
                pend_nxt    = 1'b1;
                pend_wr_nxt = ReqWR;
            end
        end

        case (state)
            S_INIT_WAIT: begin
                if (cnt == INIT_LAST) begin
                    state_nxt = S_INIT_SEQ;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_INIT_SEQ: begin
                case (step)
                    4'd0:       cmd_nxt = CMD_PCA;
                    4'd2, 4'd6: cmd_nxt = CMD_AREF;
                    4'd10: begin
                        cmd_nxt  = CMD_LDM;
                        amux_nxt = 2'd3;
                    end
                    default:    cmd_nxt = CMD_NOP;
                endcase
                if (step == 4'd12) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_IDLE: begin
                cnt_nxt = '0;
                if (RefDebt == DEBT_MAX) begin
                    state_nxt = S_REFRESH;
                end else if (pend_nxt) begin
                    state_nxt  = S_ACCESS;
                    acc_wr_nxt = pend_wr_nxt;
                    pend_nxt   = 1'b0;
                end else if (RefDebt != 3'd0) begin
                    state_nxt = S_REFRESH;
                end
            end
            S_ACCESS: begin
                // ACT, tRCD gap, RD/WR-AP, then CL2 or tWR+tRP
                case (step)
                    4'd0: begin
                        cmd_nxt  = CMD_ACT;
                        amux_nxt = 2'd1;
                    end
                    4'd2: begin
                        cmd_nxt  = acc_wr ? CMD_WRA : CMD_RD;
                        amux_nxt = 2'd2;
                        sdoe_nxt = acc_wr;
                    end
                    4'd4:    lat_nxt = !acc_wr;
                    default: cmd_nxt = CMD_NOP;
                endcase
                if (step == 4'd4) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_REFRESH: begin
                case (step)
                    4'd0:    cmd_nxt = CMD_PCA;
                    4'd2: begin
                        cmd_nxt = CMD_AREF;
                        dec     = 1'b1;
                    end
                    default: cmd_nxt = CMD_NOP;
                endcase
                if (step == 4'd5) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_INIT_WAIT;
                cnt_nxt   = '0;
            end
        endcase

        // A timer credit and an AREF on the same edge cancel out
        debt_nxt = RefDebt;
        if (tick && dec) begin
            debt_nxt = RefDebt;
        end else if (tick && (RefDebt != DEBT_MAX)) begin
            debt_nxt = RefDebt + 3'd1;
        end else if (dec && (RefDebt != 3'd0)) begin
            debt_nxt = RefDebt - 3'd1;
        end

        busy_nxt  = (state_nxt != S_IDLE);
        ready_nxt = Ready || (state_nxt == S_IDLE);
    end

endmodule

// File: tb/tb_sdram_cmd_sched.sv
// Scoreboard bench for sdram_cmd_sched with INIT_WAIT=20, REF_INTERVAL=60.
// Expected SDRAM events (any command with nRCS=0, SDOE or RDLatch) are queued
// with the clock-edge number after which they must appear; a monitor pops and
// compares every event the DUT emits. Edge numbers count from reset release.
`timescale 1ns/1ps
module tb_sdram_cmd_sched;

    localparam int unsigned INIT_WAIT    = 20;
    localparam int unsigned REF_INTERVAL = 60;

    localparam logic [3:0] C_NOP  = 4'b1111;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_WRA  = 4'b0100;
    localparam logic [3:0] C_PCA  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_LDM  = 4'b0000;

    logic       C25M = 1'b0;
    logic       nRESr = 1'b0;
    logic       CycStart = 1'b0;
    logic       ReqRD = 1'b0;
    logic       ReqWR = 1'b0;
    logic       nRCS, nRAS, nCAS, nSWE, SDOE, RDLatch, Ready, Busy, Overrun;
    logic [1:0] AMux;
    logic [2:0] RefDebt;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
        logic [1:0] am;
        logic       oe;
        logic       lt;
    } ev_t;

    ev_t exp_q[$];

    sdram_cmd_sched #(
        .INIT_WAIT   (INIT_WAIT),
        .REF_INTERVAL(REF_INTERVAL),
        .REF_DEBT_MAX(7)
    ) dut (
        .C25M    (C25M),
        .nRESr   (nRESr),
        .CycStart(CycStart),
        .ReqRD   (ReqRD),
        .ReqWR   (ReqWR),
        .nRCS    (nRCS),
        .nRAS    (nRAS),
        .nCAS    (nCAS),
        .nSWE    (nSWE),
        .SDOE    (SDOE),
        .AMux    (AMux),
        .RDLatch (RDLatch),
        .Ready   (Ready),
        .Busy    (Busy),
        .RefDebt (RefDebt),
        .Overrun (Overrun)
    );

    always #5 C25M = ~C25M;

    always @(posedge C25M or negedge nRESr) begin
        if (!nRESr) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #50us;
        $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] cmd, input logic [1:0] am,
                        input logic oe, input logic lt);
        ev_t e;
        e.cyc = c; e.cmd = cmd; e.am = am; e.oe = oe; e.lt = lt;
        exp_q.push_back(e);
    endtask

    // Access entered at edge k
    task automatic push_acc(input int k, input bit wr);
        push(k + 1, C_ACT, 2'd1, 1'b0, 1'b0);
        if (wr) push(k + 3, C_WRA, 2'd2, 1'b1, 1'b0);
        else begin
            push(k + 3, C_RD, 2'd2, 1'b0, 1'b0);
            push(k + 5, C_NOP, 2'd0, 1'b0, 1'b1);
        end
    endtask

    // Refresh entered at edge k
    task automatic push_ref(input int k);
        push(k + 1, C_PCA, 2'd0, 1'b0, 1'b0);
        push(k + 3, C_AREF, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic push_init();
        push(21, C_PCA, 2'd0, 1'b0, 1'b0);
        push(23, C_AREF, 2'd0, 1'b0, 1'b0);
        push(27, C_AREF, 2'd0, 1'b0, 1'b0);
        push(31, C_LDM, 2'd3, 1'b0, 1'b0);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge C25M);
    endtask

    // Drive CycStart with the request so it is sampled on edge k
    task automatic issue(input int k, input bit rd, input bit wr);
        wait_until(k - 1);
        CycStart = 1'b1; ReqRD = rd; ReqWR = wr;
        @(negedge C25M);
        CycStart = 1'b0; ReqRD = 1'b0; ReqWR = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd"}, 32'({nRCS, nRAS, nCAS, nSWE}), 32'(C_NOP));
        chk({tag, "_sdoe_amux_lat"}, 32'({SDOE, AMux, RDLatch}), 32'd0);
        chk({tag, "_ready"}, 32'(Ready), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd1);
        chk({tag, "_refdebt"}, 32'(RefDebt), 32'd0);
        chk({tag, "_overrun"}, 32'(Overrun), 32'd0);
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(negedge C25M);
                    if (nRESr && (!nRCS || RDLatch || SDOE)) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_event: cyc %0d cmd %b amux %0d sdoe %b rdlatch %b, none required",
                                     cyc, {nRCS, nRAS, nCAS, nSWE}, AMux, SDOE, RDLatch);
                        end else begin
                            ev_t e;
                            e = exp_q.pop_front();
                            if (e.cyc != cyc || e.cmd !== {nRCS, nRAS, nCAS, nSWE} ||
                                e.am !== AMux || e.oe !== SDOE || e.lt !== RDLatch) begin
                                errors++;
                                $display("FAIL sdram_event: got cyc %0d cmd %b amux %0d sdoe %b rdlatch %b; required cyc %0d cmd %b amux %0d sdoe %b rdlatch %b",
                                         cyc, {nRCS, nRAS, nCAS, nSWE}, AMux, SDOE, RDLatch,
                                         e.cyc, e.cmd, e.am, e.oe, e.lt);
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge C25M);
        chk_reset_outputs("reset");

        // Init sequence
        push_init();
        nRESr = 1'b1;
        wait_until(20);
        chk("nop_before_pca", 32'(nRCS), 32'd1);
        chk("ready_during_init", 32'(Ready), 32'd0);
        wait_until(33);
        chk("ready_after_init", 32'(Ready), 32'd1);
        chk("busy_after_init", 32'(Busy), 32'd0);
        chk("debt_after_init", 32'(RefDebt), 32'd0);

        // Read, combined read+write (write wins), then the first timer refresh
        push_acc(40, 1'b0);
        push_acc(48, 1'b1);
        push_ref(61);
        issue(40, 1'b1, 1'b0);
        wait_until(44);
        chk("busy_in_read", 32'(Busy), 32'd1);
        wait_until(45);
        chk("busy_after_read", 32'(Busy), 32'd0);
        issue(48, 1'b1, 1'b1);
        wait_until(52);
        chk("sdoe_one_cycle", 32'(SDOE), 32'd0);
        wait_until(60);
        chk("debt_first_tick", 32'(RefDebt), 32'd1);

        // Requests during refresh: first is held, second overruns
        push_acc(68, 1'b0);
        issue(63, 1'b1, 1'b0);
        chk("overrun_clear", 32'(Overrun), 32'd0);
        issue(64, 1'b1, 1'b0);
        chk("overrun_set", 32'(Overrun), 32'd1);
        chk("debt_after_aref", 32'(RefDebt), 32'd0);

        // Back-to-back accesses starve refresh until debt saturates
        for (int n = 0; n < 67; n++) begin
            push_acc(80 + 6 * n, n[0]);
            issue(80 + 6 * n, !n[0], n[0]);
        end
        push_ref(482);
        push_acc(489, 1'b0);
        push_ref(495);
        push_ref(502);
        push_ref(509);
        push_ref(516);
        push_ref(523);
        push_ref(530);
        push_ref(541);
        wait_until(479);
        chk("debt_six", 32'(RefDebt), 32'd6);
        wait_until(481);
        chk("debt_saturated", 32'(RefDebt), 32'd7);
        issue(482, 1'b1, 1'b0);
        chk("busy_refresh_over_pending", 32'(Busy), 32'd1);
        wait_until(485);
        chk("debt_after_sat_aref", 32'(RefDebt), 32'd6);
        wait_until(533);
        chk("debt_drained", 32'(RefDebt), 32'd0);
        wait_until(547);
        chk("idle_after_drain", 32'(Busy), 32'd0);
        chk("overrun_sticky", 32'(Overrun), 32'd1);

        // Reset in the RD cycle of an access, then full init replay
        push(561, C_ACT, 2'd1, 1'b0, 1'b0);
        push(563, C_RD, 2'd2, 1'b0, 1'b0);
        issue(560, 1'b1, 1'b0);
        wait_until(563);
        #2;
        nRESr = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        push_init();
        @(negedge C25M);
        @(negedge C25M);
        nRESr = 1'b1;
        wait_until(32);
        chk("ready_replay_low", 32'(Ready), 32'd0);
        wait_until(33);
        chk("ready_replay", 32'(Ready), 32'd1);
        chk("overrun_replay", 32'(Overrun), 32'd0);
        wait_until(45);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
